// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, key-size codes and round-constant FSM encoding
package aes_pkg;

   localparam logic [1:0] MODE_128 = 2'b00;
   localparam logic [1:0] MODE_192 = 2'b01;
   localparam logic [1:0] MODE_256 = 2'b10;

   localparam logic [3:0] N_128 = 4'd10;
   localparam logic [3:0] N_192 = 4'd8;
   localparam logic [3:0] N_256 = 4'd7;

   localparam logic [7:0] RSTART_128 = 8'h36;
   localparam logic [7:0] RSTART_192 = 8'h80;
   localparam logic [7:0] RSTART_256 = 8'h40;

   localparam logic [7:0] RPOLY = 8'h1b;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} rcon_state_t;

   // Sequence length per key size; the reserved code falls back to AES-128.
   function automatic logic [3:0] n_of(input logic [1:0] mode);
      return (mode == MODE_192) ? N_192 : (mode == MODE_256) ? N_256 : N_128;
   endfunction

   // Last constant of the forward sequence, i.e. the reverse starting point.
   function automatic logic [7:0] rstart_of(input logic [1:0] mode);
      return (mode == MODE_192) ? RSTART_192 : (mode == MODE_256) ? RSTART_256 : RSTART_128;
   endfunction

endpackage

// File: rtl/aes_gf_xtime.sv
// aes_gf_xtime: multiply and divide a GF(2^8) byte by x (shared with MixColumns)
module aes_gf_xtime
   import aes_pkg::*;
(
   input  logic [7:0] b,
   output logic [7:0] fwd,
   output logic [7:0] inv
);

   // Forward reduces the overflowed x^8 term; inverse re-inserts it when the x^0 bit is set.
   always_comb begin
      fwd = {b[6:0], 1'b0} ^ (b[7] ? RPOLY : 8'h00);
      inv = b[0] ? (((b ^ RPOLY) >> 1) | 8'h80) : (b >> 1);
   end

endmodule

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: arithmetic AES key-schedule round-constant sequencer, forward or reverse
module aes_rcon_gen
   import aes_pkg::*;
#(
   parameter int W    = 32,
   parameter int BPOS = W / 8 - 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         kld,
   input  logic [1:0]   mode,
   input  logic         dir,
   input  logic         step,
   output logic [W-1:0] out,
   output logic [3:0]   idx,
   output logic         vld,
   output logic         last,
   output logic         done
);

   rcon_state_t st;
   logic [7:0]  rc;
   logic [7:0]  rc_fwd;
   logic [7:0]  rc_inv;
   logic [3:0]  n;
   logic        sdir;

   aes_gf_xtime u_xtime (
      .b   (rc),
      .fwd (rc_fwd),
      .inv (rc_inv)
   );

   // Place the constant byte in its lane; every other bit stays zero.
   always_comb begin
      out = '0;
      out[BPOS*8 +: 8] = rc;
   end

   // Final constant is the end of the index range in the sampled direction.
   always_comb last = (st == RUN) && (sdir ? (idx == 4'd0) : (idx == n - 4'd1));

   // Sequencer: kld restarts from either end, accepted steps walk rc and idx.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st   <= IDLE;
         rc   <= 8'h00;
         idx  <= 4'd0;
         vld  <= 1'b0;
         done <= 1'b0;
         n    <= N_128;
         sdir <= 1'b0;
      end else if (kld) begin
         st   <= RUN;
         n    <= n_of(mode);
         sdir <= dir;
         rc   <= dir ? rstart_of(mode) : 8'h01;
         idx  <= dir ? n_of(mode) - 4'd1 : 4'd0;
         vld  <= 1'b1;
         done <= 1'b0;
      end else if (st == RUN && step) begin
         if (last) begin
            st   <= DONE;
            done <= 1'b1;
         end else begin
            rc  <= sdir ? rc_inv : rc_fwd;
            idx <= sdir ? idx - 4'd1 : idx + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_rcon_gen.sv
// tb_aes_rcon_gen: randomized and directed check of aes_rcon_gen against a power-of-x model
module tb_aes_rcon_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        kld = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        dir = 1'b0;
   logic        step = 1'b0;
   logic [31:0] out32;
   logic [63:0] out64;
   logic [3:0]  idx32, idx64;
   logic        vld32, vld64, last32, last64, done32, done64;

   int vectors = 0;
   int errors = 0;

   // reference model state
   logic       m_run, m_done, m_vld, m_dir;
   int         m_i, m_n;

   logic [7:0] fwd_tab [10];

   aes_rcon_gen dut32 (
      .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .step(step),
      .out(out32), .idx(idx32), .vld(vld32), .last(last32), .done(done32)
   );

   aes_rcon_gen #(.W(64), .BPOS(0)) dut64 (
      .clk(clk), .rst(rst), .kld(kld), .mode(mode), .dir(dir), .step(step),
      .out(out64), .idx(idx64), .vld(vld64), .last(last64), .done(done64)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // x^i in GF(2^8) by polynomial long division of x^i modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_pow(input int i);
      logic [15:0] p;
      p = 16'h1 << i;
      for (int b = 15; b >= 8; b--)
         if (p[b]) p = p ^ (16'h011b << (b - 8));
      return p[7:0];
   endfunction

   function automatic int n_for(input logic [1:0] md);
      return (md == 2'b01) ? 8 : (md == 2'b10) ? 7 : 10;
   endfunction

   function automatic logic m_last();
      return m_run && (m_dir ? (m_i == 0) : (m_i == m_n - 1));
   endfunction

   task automatic model_reset();
      m_run = 0; m_done = 0; m_vld = 0; m_dir = 0; m_i = 0; m_n = 10;
   endtask

   task automatic model_edge();
      if (kld) begin
         m_dir = dir; m_n = n_for(mode); m_i = dir ? m_n - 1 : 0;
         m_vld = 1; m_run = 1; m_done = 0;
      end else if (m_run && step) begin
         if (m_last()) begin
            m_run = 0; m_done = 1;
         end else begin
            m_i = m_dir ? m_i - 1 : m_i + 1;
         end
      end
   endtask

   task automatic check_all();
      logic [7:0] rcb;
      rcb = m_vld ? gf_pow(m_i) : 8'h00;
      chk("out32", 64'(out32), 64'({rcb, 24'h0}));
      chk("out64", out64, 64'(rcb));
      chk("idx32", 64'(idx32), 64'(m_i));
      chk("idx64", 64'(idx64), 64'(m_i));
      chk("vld", 64'({vld32, vld64}), 64'({m_vld, m_vld}));
      chk("last", 64'({last32, last64}), 64'({m_last(), m_last()}));
      chk("done", 64'({done32, done64}), 64'({m_done, m_done}));
      chk("idx_range", 64'(idx32 < 4'(m_n)), 64'(1));
   endtask

   task automatic tick(input logic k, input logic [1:0] md, input logic d, input logic s);
      kld = k; mode = md; dir = d; step = s;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Full sequence with out bytes checked against the published constant list.
   task automatic run_seq(input logic [1:0] md, input logic d);
      int n;
      n = n_for(md);
      tick(1'b1, md, d, 1'b0);
      for (int k = 0; k < n; k++) begin
         chk("seq_rc", 64'(out32[31:24]), 64'(fwd_tab[d ? n - 1 - k : k]));
         chk("seq_idx", 64'(idx32), 64'(d ? n - 1 - k : k));
         chk("seq_last", 64'(last32), 64'(k == n - 1));
         tick(1'b0, 2'($urandom), ~d, 1'b1);
      end
      chk("seq_done", 64'(done32), 64'(1));
      tick(1'b0, md, d, 1'b1);
      tick(1'b0, md, d, 1'b1);
      chk("done_hold_rc", 64'(out32[31:24]), 64'(d ? 8'h01 : fwd_tab[n - 1]));
   endtask

   // Pull reset between edges and confirm outputs clear without a clock.
   task automatic async_reset();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_out", out64 | 64'(out32), 64'(0));
      #2;
      rst = 1'b1;
   endtask

   initial begin
      fwd_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      model_reset();
      #12;
      check_all();
      rst = 1'b1;
      #1;
      tick(1'b0, 2'b00, 1'b0, 1'b1);
      run_seq(2'b00, 1'b0);
      run_seq(2'b00, 1'b1);
      run_seq(2'b01, 1'b0);
      run_seq(2'b10, 1'b1);
      run_seq(2'b11, 1'b0);
      tick(1'b1, 2'b00, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) tick(1'b0, 2'b00, 1'b0, 1'b1);
      chk("pre_kld_idx", 64'(idx32), 64'(5));
      tick(1'b1, 2'b00, 1'b0, 1'b1);
      chk("kld_step_out", 64'(out32), 64'(32'h0100_0000));
      chk("kld_step_idx", 64'(idx32), 64'(0));
      chk("kld_step_done", 64'(done32), 64'(0));
      tick(1'b0, 2'b00, 1'b0, 1'b1);
      tick(1'b0, 2'b00, 1'b0, 1'b1);
      async_reset();
      tick(1'b1, 2'b11, 1'b0, 1'b0);
      chk("m11_out64", out64, 64'h01);
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) == 0) async_reset();
         tick($urandom_range(0, 19) == 0, 2'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
